// File: rtl/power_pkg.sv
// power_pkg: shared state encoding, width helpers and default operand width for power_unit.
package power_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, SQ, CB, DONE} state_t;
  function automatic int sq_w(input int w);
    return 2 * w;
  endfunction
  function automatic int cb_w(input int w);
    return 3 * w;
  endfunction
endpackage

// File: rtl/power_unit_shift_add_step.sv
// shift_add_step: one LSB-first shift-add multiply iteration (acc, multiplicand, multiplier) -> next values; combinational.
module shift_add_step
  import power_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [cb_w(WIDTH)-1:0] acc,
  input  logic [cb_w(WIDTH)-1:0] mcand,
  input  logic [WIDTH-1:0]       mplier,
  output logic [cb_w(WIDTH)-1:0] acc_n,
  output logic [cb_w(WIDTH)-1:0] mcand_n,
  output logic [WIDTH-1:0]       mplier_n
);
  assign acc_n    = mplier[0] ? acc + mcand : acc;
  assign mcand_n  = mcand << 1;
  assign mplier_n = mplier >> 1;
endmodule

// File: rtl/power_unit.sv
// power_unit: iterative square/cube of an unsigned operand using one shared shift-add step.
// Ports: clk, rst (sync, active-high), start/number in; busy, done (1-cycle pulse), square, cube out.
// Optional macro POWER_EARLY_EXIT_EN: each phase ends as soon as the shifted multiplier reaches zero.
module power_unit
  import power_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       number,
  output logic                   busy,
  output logic                   done,
  output logic [sq_w(WIDTH)-1:0] square,
  output logic [cb_w(WIDTH)-1:0] cube
);
  localparam int SW = sq_w(WIDTH);
  localparam int CW = cb_w(WIDTH);
  localparam int NW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state, state_n;
  logic [WIDTH-1:0] x_reg, mplier, mplier_n;
  logic [CW-1:0] acc, acc_n, mcand, mcand_n;
  logic [SW-1:0] sq_reg;
  logic [NW-1:0] cnt;
  logic last;
  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc), .mcand(mcand), .mplier(mplier),
    .acc_n(acc_n), .mcand_n(mcand_n), .mplier_n(mplier_n)
  );
`ifdef POWER_EARLY_EXIT_EN
  assign last = cnt == NW'(WIDTH - 1) || mplier_n == '0;
`else
  assign last = cnt == NW'(WIDTH - 1);
`endif
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? SQ : IDLE) :
              state == SQ   ? (last ? CB : SQ) :
              state == CB   ? (last ? DONE : CB) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      square <= '0;
      cube   <= '0;
      x_reg  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      sq_reg <= '0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_reg  <= number;
          acc    <= '0;
          mcand  <= CW'(number);
          mplier <= number;
          cnt    <= '0;
          busy   <= 1'b1;
        end
        SQ: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            sq_reg <= acc_n[SW-1:0];
            acc    <= '0;
            mcand  <= CW'(acc_n[SW-1:0]);
            mplier <= x_reg;
          end else begin
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
          end
        end
        CB: begin
          cnt    <= cnt + 1'b1;
          acc    <= acc_n;
          mcand  <= mcand_n;
          mplier <= mplier_n;
        end
        DONE: begin
          square <= sq_reg;
          cube   <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_power_unit.sv
// tb_power_unit: scoreboard bench for power_unit; stimulus pushes expected results, a monitor checks each done pulse.
module tb_power_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] number = '0;
  logic busy, done;
  logic [31:0] square;
  logic [47:0] cube;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  typedef struct {
    logic [31:0] sq;
    logic [47:0] cb;
    int acc;
    int lat;
  } exp_t;
  exp_t q[$];

  power_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .number(number),
    .busy(busy), .done(done), .square(square), .cube(cube)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int lat_of(input logic [15:0] n);
    int p;
    p = 1;
`ifdef POWER_EARLY_EXIT_EN
    for (int i = 0; i < 16; i++) if (n[i]) p = i + 1;
`else
    p = 16;
`endif
    return 2 * p + 1;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check("square", 64'(square), 64'(e.sq));
        check("cube", 64'(cube), 64'(e.cb));
        check("latency", 64'(cyc - e.acc), 64'(e.lat));
        check("busy_in_done", 64'(busy), 64'(0));
      end
    end
  end

  task automatic issue(input logic [15:0] n, input logic [31:0] sq, input logic [47:0] cb, input bit push);
    @(negedge clk);
    number = n;
    start = 1'b1;
    if (push) q.push_back('{sq, cb, cyc + 1, lat_of(n)});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) begin
      check("done_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    number = 16'd5;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_square", 64'(square), 64'(0));
    check("rst_cube", 64'(cube), 64'(0));
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));

    issue(16'd3, 32'd9, 48'd27, 1'b1);
    drain();
    issue(16'hFFFF, 32'hFFFE0001, 48'hFFFD0002FFFF, 1'b1);
    drain();

    issue(16'd4, 32'd16, 48'd64, 1'b1);
    repeat (3) @(negedge clk);
    number = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    issue(16'd9, 32'd0, 48'd0, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_square", 64'(square), 64'(0));
    check("abort_cube", 64'(cube), 64'(0));
    repeat (40) @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'(0));

    issue(16'd2, 32'd4, 48'd8, 1'b1);
    drain();
    issue(16'd0, 32'd0, 48'd0, 1'b1);
    drain();
    issue(16'd5, 32'd25, 48'd125, 1'b1);
    drain();
    issue(16'd255, 32'd65025, 48'd16581375, 1'b1);
    drain();
    issue(16'd1000, 32'd1000000, 48'd1000000000, 1'b1);
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
